// File: rtl/conv_mem_pkg.sv
// rtl/conv_mem_pkg.sv - shared widths, byte-lane merge and address decode for conv_mem
package conv_mem_pkg;

    localparam int WORD_W = 32;
    localparam int BYTES  = 4;

    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BYTES-1:0]  strb
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BYTES; i++) begin
            if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

    // Word index relative to the instance base; callers truncate to their array width.
    function automatic logic [31:0] addr_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return (addr - base) >> 2;
    endfunction

    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] depth
    );
        return (addr >= base) && (addr_index(addr, base) < depth);
    endfunction

endpackage

// File: rtl/conv_mem_bank.sv
// rtl/conv_mem_bank.sv - byte-lane SRAM array, per-lane write enables, registered read
module conv_mem_bank
    import conv_mem_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic              clk,
    input  logic [BYTES-1:0]  we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    // Read and write share an edge, so a same-word access returns the pre-write value.
    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (we[i]) lane_mem[waddr] <= wdata[8*i +: 8];
            if (re)    rd_q <= lane_mem[raddr];
        end

        assign rdata[8*i +: 8] = rd_q;
    end

endmodule

// File: rtl/conv_mem.sv
// rtl/conv_mem.sv - SRAM responder for one conv master port; CONV_MEM_FWD_EN enables same-cycle write-to-read forwarding
module conv_mem
    import conv_mem_pkg::*;
#(
    parameter int          DEPTH = 16384,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S_R_req,
    input  logic [31:0]       S_addr,
    output logic [WORD_W-1:0] S_R_data,
    input  logic [BYTES-1:0]  S_W_req,
    input  logic [WORD_W-1:0] S_W_data,
    input  logic              H_req,
    input  logic              H_we,
    input  logic [31:0]       H_addr,
    input  logic [WORD_W-1:0] H_wdata,
    output logic              H_ready,
    output logic [WORD_W-1:0] H_rdata,
    output logic              err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              m_ok, h_ok, m_busy, h_go;
    logic [AW-1:0]     m_idx, h_idx;
    logic [BYTES-1:0]  bank_we;
    logic [AW-1:0]     bank_waddr, bank_raddr;
    logic [WORD_W-1:0] bank_wdata, bank_rdata, m_word;
    logic              bank_re;

    logic              m_rd_q, m_hit_q, h_rd_q, h_hit_q;
    logic [WORD_W-1:0] s_hold_q, h_hold_q;

    assign m_ok   = addr_in_range(S_addr, BASE, 32'(DEPTH));
    assign h_ok   = addr_in_range(H_addr, BASE, 32'(DEPTH));
    assign m_idx  = AW'(addr_index(S_addr, BASE));
    assign h_idx  = AW'(addr_index(H_addr, BASE));

    // Master always wins; the host only gets the array on fully idle master cycles.
    assign m_busy  = S_R_req | (|S_W_req);
    assign h_go    = rst & H_req & ~m_busy;
    assign H_ready = h_go;

    always_comb begin
        bank_we = '0;
        if (rst) begin
            if (m_ok && (|S_W_req))
                bank_we = S_W_req;
            else if (h_go && H_we && h_ok)
                bank_we = '1;
        end
    end

    assign bank_waddr = m_busy ? m_idx : h_idx;
    assign bank_wdata = m_busy ? S_W_data : H_wdata;
    assign bank_re    = (S_R_req & m_ok) | (h_go & ~H_we & h_ok);
    assign bank_raddr = S_R_req ? m_idx : h_idx;

    conv_mem_bank #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (bank_waddr),
        .wdata (bank_wdata),
        .re    (bank_re),
        .raddr (bank_raddr),
        .rdata (bank_rdata)
    );

`ifdef CONV_MEM_FWD_EN
    logic [BYTES-1:0]  fwd_strb_q;
    logic [WORD_W-1:0] fwd_data_q;

    // Read and write share S_addr, so a same-cycle pair always targets one word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_strb_q <= '0;
            fwd_data_q <= '0;
        end else begin
            fwd_strb_q <= (S_R_req && m_ok) ? S_W_req : '0;
            fwd_data_q <= S_W_data;
        end
    end

    assign m_word = merge_bytes(bank_rdata, fwd_data_q, fwd_strb_q);
`else
    assign m_word = bank_rdata;
`endif

    assign S_R_data = m_rd_q ? (m_hit_q ? m_word : '0) : s_hold_q;
    assign H_rdata  = h_rd_q ? (h_hit_q ? bank_rdata : '0) : h_hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rd_q   <= 1'b0;
            m_hit_q  <= 1'b0;
            h_rd_q   <= 1'b0;
            h_hit_q  <= 1'b0;
            s_hold_q <= '0;
            h_hold_q <= '0;
            err      <= 1'b0;
        end else begin
            m_rd_q   <= S_R_req;
            m_hit_q  <= m_ok;
            h_rd_q   <= h_go & ~H_we;
            h_hit_q  <= h_ok;
            s_hold_q <= S_R_data;
            h_hold_q <= H_rdata;
            if ((m_busy && !m_ok) || (h_go && !h_ok))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_mem.sv
// tb/tb_conv_mem.sv - randomized and directed checks of conv_mem against an array model
module tb_conv_mem;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        S_R_req;
    logic [31:0] S_addr;
    logic [31:0] S_R_data;
    logic [3:0]  S_W_req;
    logic [31:0] S_W_data;
    logic        H_req;
    logic        H_we;
    logic [31:0] H_addr;
    logic [31:0] H_wdata;
    logic        H_ready;
    logic [31:0] H_rdata;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_sr  = 32'h0;
    logic [31:0] exp_hr  = 32'h0;
    logic        exp_err = 1'b0;

    conv_mem #(
        .DEPTH (DEPTH),
        .BASE  (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .S_R_req  (S_R_req),
        .S_addr   (S_addr),
        .S_R_data (S_R_data),
        .S_W_req  (S_W_req),
        .S_W_data (S_W_data),
        .H_req    (H_req),
        .H_we     (H_we),
        .H_addr   (H_addr),
        .H_wdata  (H_wdata),
        .H_ready  (H_ready),
        .H_rdata  (H_rdata),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic idle();
        S_R_req = 1'b0; S_W_req = 4'h0; S_addr = 32'h0; S_W_data = 32'h0;
        H_req = 1'b0; H_we = 1'b0; H_addr = 32'h0; H_wdata = 32'h0;
    endtask

    // One master cycle; called at posedge+1, returns at the following posedge+1.
    task automatic m_op(input bit rd, input logic [3:0] strb, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
        bit ok;
        int ix;
        logic [31:0] old_w, new_w;
        S_R_req = rd; S_W_req = strb; S_addr = a; S_W_data = d;
        ok = in_rng(a);
        ix = ok ? word_of(a) : 0;
        old_w = model[ix];
        new_w = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) new_w[8*b +: 8] = d[8*b +: 8];
        @(posedge clk); #1;
        if (rd) begin
`ifdef CONV_MEM_FWD_EN
            exp_sr = ok ? new_w : 32'h0;
`else
            exp_sr = ok ? old_w : 32'h0;
`endif
        end
        if (ok && strb != 4'h0) model[ix] = new_w;
        if (!ok && (rd || strb != 4'h0)) exp_err = 1'b1;
        check(tag, S_R_data, exp_sr);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    task automatic host_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                               input string tag);
        int n;
        bit ok;
        ok = in_rng(a);
        S_R_req = 1'b0; S_W_req = 4'h0;
        H_req = 1'b1; H_we = we; H_addr = a; H_wdata = d;
        #1;
        n = 0;
        while (H_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, 32'(H_ready), 32'd1);
        check({tag, "_wait"}, 32'(n), 32'd0);
        @(posedge clk); #1;
        H_req = 1'b0; H_we = 1'b0;
        if (!ok) exp_err = 1'b1;
        if (we) begin
            if (ok) model[word_of(a)] = d;
        end else begin
            exp_hr = ok ? model[word_of(a)] : 32'h0;
            check({tag, "_rdata"}, H_rdata, exp_hr);
        end
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        rst = 1'b0;
        idle();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sr", S_R_data, 32'h0);
        check("rst_hr", H_rdata, 32'h0);
        check("rst_ready", 32'(H_ready), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Host preload then master readback
        host_access(1'b1, BASE + 32'h10, 32'h1122_3344, "tp1_hw");
        m_op(1'b1, 4'h0, BASE + 32'h10, 32'h0, "tp1_rd");
        check("tp1_const", S_R_data, 32'h1122_3344);

        // Byte-strobed write
        m_op(1'b0, 4'b0101, BASE + 32'h10, 32'hAABB_CCDD, "tp2_wr");
        m_op(1'b1, 4'h0, BASE + 32'h10, 32'h0, "tp2_rd");
        check("tp2_const", S_R_data, 32'h11BB_33DD);

        // Same-cycle read and write to one word
        host_access(1'b1, BASE + 32'h20, 32'h0, "tp3_hw");
        m_op(1'b1, 4'hF, BASE + 32'h20, 32'hDEAD_BEEF, "tp3_rw");
`ifdef CONV_MEM_FWD_EN
        check("tp3_const", S_R_data, 32'hDEAD_BEEF);
`else
        check("tp3_const", S_R_data, 32'h0);
`endif
        m_op(1'b1, 4'h0, BASE + 32'h20, 32'h0, "tp3_after");
        check("tp3_after_const", S_R_data, 32'hDEAD_BEEF);
        idle();

        // Host read stalled by three master reads
        H_req = 1'b1; H_we = 1'b0; H_addr = BASE + 32'h10;
        for (int c = 0; c < 3; c++) begin
            S_R_req = 1'b1; S_addr = BASE + 32'h20;
            #1;
            check("tp4_stall", 32'(H_ready), 32'h0);
            @(posedge clk); #1;
            check("tp4_mrd", S_R_data, 32'hDEAD_BEEF);
        end
        S_R_req = 1'b0;
        #1;
        check("tp4_accept", 32'(H_ready), 32'h1);
        @(posedge clk); #1;
        H_req = 1'b0;
        check("tp4_hrdata", H_rdata, 32'h11BB_33DD);
        check("tp4_sr_hold", S_R_data, 32'hDEAD_BEEF);

        // Fill the whole array with random words
        for (int i = 0; i < DEPTH; i++)
            host_access(1'b1, BASE + 32'(i * 4), $urandom, "fill");

        // Random master traffic with occasional host reads
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0)
                a = BASE + 32'($urandom_range(0, 3) * 4);
            else
                a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
            s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            m_op(1'($urandom_range(0, 1)), s, a, $urandom, "rnd");
            if (it % 16 == 15) begin
                idle();
                host_access(1'b0, BASE + 32'($urandom_range(0, DEPTH - 1) * 4), 32'h0, "rnd_h");
                check("rnd_h_sr_hold", S_R_data, exp_sr);
            end
        end
        idle();
        check("pre_oor_err", 32'(err), 32'h0);

        // Out-of-range accesses
        m_op(1'b0, 4'hF, BASE + 32'(DEPTH * 4), 32'hCAFE_F00D, "oor_wr");
        check("oor_err_const", 32'(err), 32'h1);
        m_op(1'b1, 4'h0, BASE + 32'(DEPTH * 4), 32'h0, "oor_rd");
        m_op(1'b1, 4'h0, BASE + 32'((DEPTH - 1) * 4), 32'h0, "oor_last");
        m_op(1'b1, 4'h0, BASE, 32'h0, "oor_first");
        m_op(1'b1, 4'h0, BASE - 32'h4, 32'h0, "oor_below");
        idle();
        host_access(1'b0, BASE + 32'(DEPTH * 4), 32'h0, "oor_hrd");
        host_access(1'b1, BASE - 32'h4, 32'h1234_5678, "oor_hwr");

        // Reset in the middle of a read burst
        for (int i = 0; i < 3; i++)
            m_op(1'b1, 4'h0, BASE + 32'((i + 5) * 4), 32'h0, "burst");
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_sr", S_R_data, 32'h0);
        check("mid_rst_err", 32'(err), 32'h0);
        check("mid_rst_hr", H_rdata, 32'h0);
        idle();
        exp_sr = 32'h0; exp_hr = 32'h0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_sr", S_R_data, 32'h0);
        for (int i = 0; i < 8; i++)
            m_op(1'b1, 4'h0, BASE + 32'($urandom_range(0, DEPTH - 1) * 4), 32'h0, "post_rst");
        m_op(1'b1, 4'h0, BASE + 32'h20, 32'h0, "post_rst_w8");
        idle();
        host_access(1'b0, BASE + 32'h10, 32'h0, "post_rst_h");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_mem.md
# conv_mem

Single-port word-organised SRAM responder serving one master port of the `conv` engine's memory interface (the M0/M1/M2 request/address/data/byte-strobe protocol). It answers master reads with fixed one-cycle latency and applies byte-masked writes. A secondary host port lets the testbench or loader preload images and weights and dump results, with stall-based arbitration. One instance is placed per master port (image, weight, result memories).

## Interface
Parameters:
- DEPTH, 16384: number of 32-bit words.
- BASE, 32'h0000_0000: byte address mapped to word 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- S_R_req  in  1  master read request.
- S_addr  in  32  master byte address; bits [1:0] ignored.
- S_R_data  out  32  master read data.
- S_W_req  in  4  master byte write strobes; bit i writes byte lane i, data bits [8i+7:8i].
- S_W_data  in  32  master write data.
- H_req  in  1  host access request.
- H_we  in  1  host write (1) / read (0), full-word.
- H_addr  in  32  host byte address.
- H_wdata  in  32  host write data.
- H_ready  out  1  host request accepted this cycle.
- H_rdata  out  32  host read data.
- err  out  1  sticky out-of-range flag.

## Operation
- Word index = (addr − BASE) >> 2. An address is in range iff addr ≥ BASE and index < DEPTH.
- Master read (S_R_req=1, in range): S_R_data is the word value in the next cycle. It holds until the next master read completes.
- Master write (S_W_req≠0, in range): only the strobed lanes are updated at the clock edge. S_W_req=0 means no write.
- Simultaneous master read and write in one cycle is legal. The write is committed and the read is performed, so both can target the same word. See Configuration for the read value.
- Out-of-range master read: S_R_data=0 next cycle and err←1. Out-of-range write: dropped and err←1.
- Host arbitration: the master has absolute priority. H_ready = H_req & ~(S_R_req | (|S_W_req)).
- The host holds H_req, H_we, H_addr and H_wdata stable until H_ready=1.
- On an accepted host read, H_rdata is valid the next cycle and is held until the next accepted host read.
- A host write writes all 4 lanes.
- Out-of-range host access sets err. The write is dropped; a read returns 0.
- err is cleared only by reset.
- Memory contents are not reset and are undefined until written.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately.
  - A write on the edge coinciding with reset assertion is not guaranteed.
  - Array contents are otherwise preserved.

## Timing
- Reset values: S_R_data=0, H_rdata=0, H_ready=0 (combinational, 0 while H_req=0), err=0.
- Read latency is exactly 1 cycle, master and host, with no wait states for the master.
- Back-to-back master reads return one word per cycle.
- Write-then-read of the same word in consecutive cycles returns the new data.
- The host sees a worst-case unbounded stall while the master is continuously active. There is no fairness guarantee; the loader only operates while conv is idle.
- err rises in the cycle after the offending request.

## Configuration
- CONV_MEM_FWD_EN defined: a same-cycle master read and write to the same word returns the merged new value. Strobed lanes come from S_W_data, the rest from the old word.
- Without CONV_MEM_FWD_EN: the same case returns the old word (read-before-write).
- All other behaviour is identical.

## Structure
- Package conv_mem_pkg holds:
  - WORD_W=32 and BYTES=4.
  - The byte-lane merge function (old, new, strobe → merged).
  - The address-to-index/in-range decode function.
- Sub-module conv_mem_bank: a byte-lane storage array with per-lane write enables and a registered read. conv_mem wraps it with decode, arbitration, forwarding and the err logic.

## Test plan
- Preload via host: write 0x11223344 to BASE+0x10 → H_ready=1 the same cycle. A master read of BASE+0x10 returns 0x11223344 one cycle later.
- Master byte write with S_W_req=4'b0101, data 0xAABBCCDD, to a word holding 0x11223344 → a subsequent read returns 0x11BB33DD.
- Same-cycle read and write to one word, S_W_req=4'hF, data 0xDEADBEEF, old value 0x0 → returns 0xDEADBEEF with CONV_MEM_FWD_EN, 0x00000000 without.
- Host read held while the master reads for 3 cycles → H_ready=0 for those 3 cycles, 1 on the 4th. H_rdata is correct the cycle after acceptance.
- Master write to BASE+DEPTH*4 → err=1 next cycle and no word is modified. A read at the same address returns 0.
- Assert rst during a burst of reads → S_R_data=0 and err=0 immediately. Previously written words are intact after reset release.
